// File: rtl/ir_nec_pkg.sv
// Shared NEC timing constants and transmitter state encoding.
// The repeat-code states exist only when IR_TX_REPEAT_EN is defined.
package ir_nec_pkg;

  localparam int UNIT_CYC_DEF     = 28125;
  localparam int CARRIER_HALF_DEF = 658;

  localparam int LEAD_MARK_U  = 16;
  localparam int LEAD_SPACE_U = 8;
  localparam int BIT_U        = 1;
  localparam int ONE_SPACE_U  = 3;
  localparam int REP_SPACE_U  = 4;
  localparam int FRAME_U      = 121;
  localparam int REP_PERIOD_U = 196;

  // Gap lengths chosen so every sequence starts one full repeat period after the previous one
  localparam int REP_SEQ_U       = LEAD_MARK_U + REP_SPACE_U + BIT_U;
  localparam int REP_GAP_FRAME_U = REP_PERIOD_U - FRAME_U;
  localparam int REP_GAP_REP_U   = REP_PERIOD_U - REP_SEQ_U;

  typedef enum logic [3:0] {
    IDLE,
    LEAD_MARK,
    LEAD_SPACE,
    BIT_MARK,
    BIT_SPACE,
    STOP_MARK
`ifdef IR_TX_REPEAT_EN
    ,
    REP_GAP,
    REP_MARK,
    REP_SPACE,
    REP_STOP
`endif
  } state_t;

  function automatic logic is_mark(input state_t s);
    logic m;
    m = 1'b0;
    case (s)
      LEAD_MARK, BIT_MARK, STOP_MARK: m = 1'b1;
`ifdef IR_TX_REPEAT_EN
      REP_MARK, REP_STOP:             m = 1'b1;
`endif
      default:                        m = 1'b0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/ir_carrier_gen.sv
// Restartable 50% duty carrier; a restart makes the next cycle begin a full high half-period.
module ir_carrier_gen
  import ir_nec_pkg::*;
#(
  parameter int CARRIER_HALF = CARRIER_HALF_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  input  logic en,
  output logic carrier_o
);

  localparam int CW = (CARRIER_HALF > 1) ? $clog2(CARRIER_HALF) : 1;
  localparam logic [CW-1:0] HALF_LAST = CW'(CARRIER_HALF - 1);

  logic [CW-1:0] halfCnt_q, halfCnt_d;
  logic          carrier_q, carrier_d;

  always_comb begin
    halfCnt_d = halfCnt_q;
    carrier_d = carrier_q;
    if (restart) begin
      halfCnt_d = '0;
      carrier_d = 1'b1;
    end else if (en) begin
      if (halfCnt_q == HALF_LAST) begin
        halfCnt_d = '0;
        carrier_d = ~carrier_q;
      end else begin
        halfCnt_d = halfCnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      halfCnt_q <= '0;
      carrier_q <= 1'b0;
    end else begin
      halfCnt_q <= halfCnt_d;
      carrier_q <= carrier_d;
    end
  end

  assign carrier_o = carrier_q;

endmodule

// File: rtl/ir_nec_tx.sv
// NEC infrared frame transmitter: leader, 32 LSB-first data bits, stop mark, modulated and envelope outputs.
// Defining IR_TX_REPEAT_EN adds key-held repeat codes driven by rep_hold.
module ir_nec_tx
  import ir_nec_pkg::*;
#(
  parameter int UNIT_CYC     = UNIT_CYC_DEF,
  parameter int CARRIER_HALF = CARRIER_HALF_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] addr,
  input  logic [7:0] cmd,
  input  logic       rep_hold,
  output logic       busy,
  output logic       done,
  output logic       ir_out,
  output logic       ir_env
);

  localparam logic [14:0] UNIT_LAST = 15'(UNIT_CYC - 1);

  state_t      state_q, state_d;
  logic [14:0] cycCnt_q, cycCnt_d;
  logic [7:0]  unitCnt_q, unitCnt_d;
  logic [5:0]  bitCnt_q, bitCnt_d;
  logic [31:0] shiftReg_q, shiftReg_d;
  logic        done_q, done_d;

  logic        unitTick;
  logic        stateEnd;
  logic [7:0]  stateUnits;
  logic        markNow;
  logic        carrierRestart;
  logic        carrier;

`ifdef IR_TX_REPEAT_EN
  logic        gapLong_q, gapLong_d;
`else
  logic        repHoldUnused;
  assign repHoldUnused = rep_hold;
`endif

  // Length of the current state in NEC units; data spaces depend on the bit being sent
  always_comb begin
    stateUnits = 8'(BIT_U);
    case (state_q)
      LEAD_MARK:  stateUnits = 8'(LEAD_MARK_U);
      LEAD_SPACE: stateUnits = 8'(LEAD_SPACE_U);
      BIT_SPACE:  stateUnits = shiftReg_q[0] ? 8'(ONE_SPACE_U) : 8'(BIT_U);
`ifdef IR_TX_REPEAT_EN
      REP_GAP:    stateUnits = gapLong_q ? 8'(REP_GAP_REP_U) : 8'(REP_GAP_FRAME_U);
      REP_MARK:   stateUnits = 8'(LEAD_MARK_U);
      REP_SPACE:  stateUnits = 8'(REP_SPACE_U);
`endif
      default:    stateUnits = 8'(BIT_U);
    endcase
  end

  assign unitTick = (cycCnt_q == UNIT_LAST);
  assign stateEnd = (state_q != IDLE) && unitTick && (unitCnt_q == stateUnits - 8'd1);

  // The cycle counter runs freely through the whole sequence, so every boundary stays on a unit multiple
  always_comb begin
    state_d    = state_q;
    cycCnt_d   = cycCnt_q;
    unitCnt_d  = unitCnt_q;
    bitCnt_d   = bitCnt_q;
    shiftReg_d = shiftReg_q;
    done_d     = 1'b0;
`ifdef IR_TX_REPEAT_EN
    gapLong_d  = gapLong_q;
`endif
    if (state_q == IDLE) begin
      if (start) begin
        state_d    = LEAD_MARK;
        cycCnt_d   = '0;
        unitCnt_d  = '0;
        bitCnt_d   = '0;
        shiftReg_d = {~cmd, cmd, ~addr, addr};
      end
    end else begin
      cycCnt_d = unitTick ? 15'd0 : cycCnt_q + 15'd1;
      if (unitTick) begin
        unitCnt_d = stateEnd ? 8'd0 : unitCnt_q + 8'd1;
      end
      if (stateEnd) begin
        case (state_q)
          LEAD_MARK:  state_d = LEAD_SPACE;
          LEAD_SPACE: state_d = BIT_MARK;
          BIT_MARK:   state_d = BIT_SPACE;
          BIT_SPACE: begin
            shiftReg_d = shiftReg_q >> 1;
            bitCnt_d   = bitCnt_q + 6'd1;
            state_d    = (bitCnt_q == 6'd31) ? STOP_MARK : BIT_MARK;
          end
          STOP_MARK: begin
`ifdef IR_TX_REPEAT_EN
            if (rep_hold) begin
              state_d   = REP_GAP;
              gapLong_d = 1'b0;
            end else begin
              state_d = IDLE;
              done_d  = 1'b1;
            end
`else
            state_d = IDLE;
            done_d  = 1'b1;
`endif
          end
`ifdef IR_TX_REPEAT_EN
          REP_GAP:   state_d = REP_MARK;
          REP_MARK:  state_d = REP_SPACE;
          REP_SPACE: state_d = REP_STOP;
          REP_STOP: begin
            if (rep_hold) begin
              state_d   = REP_GAP;
              gapLong_d = 1'b1;
            end else begin
              state_d = IDLE;
              done_d  = 1'b1;
            end
          end
`endif
          default: state_d = IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cycCnt_q   <= '0;
      unitCnt_q  <= '0;
      bitCnt_q   <= '0;
      shiftReg_q <= '0;
      done_q     <= 1'b0;
`ifdef IR_TX_REPEAT_EN
      gapLong_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cycCnt_q   <= cycCnt_d;
      unitCnt_q  <= unitCnt_d;
      bitCnt_q   <= bitCnt_d;
      shiftReg_q <= shiftReg_d;
      done_q     <= done_d;
`ifdef IR_TX_REPEAT_EN
      gapLong_q  <= gapLong_d;
`endif
    end
  end

  // Restart the carrier one cycle early so the first mark cycle is already high
  assign markNow        = is_mark(state_q);
  assign carrierRestart = is_mark(state_d) && !markNow;

  ir_carrier_gen #(
    .CARRIER_HALF(CARRIER_HALF)
  ) u_carrier (
    .clk      (clk),
    .rst_n    (rst_n),
    .restart  (carrierRestart),
    .en       (markNow),
    .carrier_o(carrier)
  );

  assign busy   = (state_q != IDLE);
  assign done   = done_q;
  assign ir_out = markNow & carrier;
  assign ir_env = ~markNow;

endmodule
